// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding, default word width and counter sizing for the piso_tx transmitter.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_e;

    localparam int PISO_DATA_W = 8;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// piso_bit_cnt: clearable bit counter with a terminal-count flag at DATA_W-1, marks the last data bit of a frame.
module piso_bit_cnt
    import piso_pkg::*;
#(
    parameter int DATA_W = PISO_DATA_W,
    parameter int CW     = cnt_w(DATA_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          tc
);

    assign tc = count == CW'(DATA_W - 1);

    // Holds at terminal count so it never wraps mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && !tc)
            count <= count + CW'(1);
    end

endmodule

// File: rtl/piso_tx.sv
// piso_tx: valid/ready parallel-in serial-out transmitter, MSB-first with frame_start/done framing.
// Define PISO_TX_PARITY_EN to append an even-parity bit to each frame.
module piso_tx
    import piso_pkg::*;
#(
    parameter int DATA_W = PISO_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              serial_out,
    output logic              bit_valid,
    output logic              frame_start,
    output logic              done,
    output logic              busy
);

    localparam int CW = cnt_w(DATA_W);

    piso_state_e       state;
    logic [DATA_W-1:0] shift;
    logic [CW-1:0]     cnt;
    logic              tc;
    logic              last;
    logic              xfer;
    logic              adv;

`ifdef PISO_TX_PARITY_EN
    logic par;
    assign last = state == PARITY;
`else
    assign last = (state == SHIFT) && tc;
`endif

    assign load_ready = (state == IDLE) || last;
    assign xfer       = load_valid && load_ready;
    assign adv        = (state == SHIFT) && !tc;

    piso_bit_cnt #(.DATA_W(DATA_W), .CW(CW)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (xfer || last),
        .inc   (adv),
        .count (cnt),
        .tc    (tc)
    );

    // The MSB goes straight out on the transfer edge; shift holds the remaining bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shift       <= '0;
            serial_out  <= 1'b0;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            par         <= 1'b0;
`endif
        end else if (xfer) begin
            state       <= SHIFT;
            shift       <= data_in << 1;
            serial_out  <= data_in[DATA_W-1];
            bit_valid   <= 1'b1;
            frame_start <= 1'b1;
            done        <= 1'b0;
            busy        <= 1'b1;
`ifdef PISO_TX_PARITY_EN
            par         <= ^data_in;
`endif
        end else if (adv) begin
            shift       <= shift << 1;
            serial_out  <= shift[DATA_W-1];
            frame_start <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            done        <= 1'b0;
`else
            done        <= cnt == CW'(DATA_W - 2);
`endif
`ifdef PISO_TX_PARITY_EN
        end else if (state == SHIFT) begin
            state       <= PARITY;
            serial_out  <= par;
            frame_start <= 1'b0;
            done        <= 1'b1;
`endif
        end else if (last) begin
            state       <= IDLE;
            shift       <= '0;
            serial_out  <= 1'b0;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed self-checking bench for piso_tx (parity cases only with PISO_TX_PARITY_EN).
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       load_valid = 1'b0;
    logic       load_ready, serial_out, bit_valid, frame_start, done, busy;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    piso_tx #(.DATA_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .serial_out  (serial_out),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .done        (done),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, ".load_ready"}, 32'(load_ready), 32'd1);
        chk({tag, ".serial_out"}, 32'(serial_out), 32'd0);
        chk({tag, ".bit_valid"}, 32'(bit_valid), 32'd0);
        chk({tag, ".frame_start"}, 32'(frame_start), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    // One frame bit: load_ready is expected high exactly when done is.
    task automatic bit_chk(input string tag, input logic b, input logic fs, input logic dn);
        chk({tag, ".serial_out"}, 32'(serial_out), 32'(b));
        chk({tag, ".frame_start"}, 32'(frame_start), 32'(fs));
        chk({tag, ".done"}, 32'(done), 32'(dn));
        chk({tag, ".load_ready"}, 32'(load_ready), 32'(dn));
        chk({tag, ".bit_valid"}, 32'(bit_valid), 32'd1);
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        @(negedge clk);
    endtask

    task automatic start(input logic [7:0] d);
        data_in    = d;
        load_valid = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] v;
        repeat (2) @(negedge clk);
        chk("rst_held.load_ready", 32'(load_ready), 32'd1);
        chk("rst_held.busy", 32'(busy), 32'd0);
        rst = 1'b0;
        idle_chk("reset");
        @(negedge clk);
`ifndef PISO_TX_PARITY_EN
        v = 16'h00A5;
        start(v[7:0]);
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++)
            bit_chk($sformatf("a5_b%0d", i), v[7-i], i == 0, i == 7);
        idle_chk("a5_after");

        v = 16'hF00F;
        start(v[15:8]);
        data_in = v[7:0];
        for (int i = 0; i < 16; i++) begin
            if (i == 8) load_valid = 1'b0;
            bit_chk($sformatf("b2b_b%0d", i), v[15-i], i == 0 || i == 8, i == 7 || i == 15);
        end
        idle_chk("b2b_after");

        v = 16'hC33C;
        start(v[15:8]);
        load_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                data_in    = v[7:0];
                load_valid = 1'b1;
            end
            if (i == 8) load_valid = 1'b0;
            bit_chk($sformatf("bp_b%0d", i), v[15-i], i == 0 || i == 8, i == 7 || i == 15);
        end
        idle_chk("bp_after");

        v = 16'h00FF;
        start(v[7:0]);
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++)
            bit_chk($sformatf("abort_b%0d", i), 1'b1, i == 0, 1'b0);
        rst = 1'b1;
        #1;
        chk("abort.serial_out", 32'(serial_out), 32'd0);
        chk("abort.bit_valid", 32'(bit_valid), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_chk("abort_idle");
        @(negedge clk);
        idle_chk("abort_idle2");
        v = 16'h0081;
        start(v[7:0]);
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++)
            bit_chk($sformatf("x81_b%0d", i), v[7-i], i == 0, i == 7);
        idle_chk("x81_after");
`else
        v = 16'h000F;
        start(8'h07);
        load_valid = 1'b0;
        for (int i = 0; i < 9; i++)
            bit_chk($sformatf("par07_b%0d", i), v[8-i], i == 0, i == 8);
        idle_chk("par07_after");

        v = 16'h0006;
        start(8'h03);
        load_valid = 1'b0;
        for (int i = 0; i < 9; i++)
            bit_chk($sformatf("par03_b%0d", i), v[8-i], i == 0, i == 8);
        idle_chk("par03_after");
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out transmitter that feeds the 8-bit serial-in/parallel-out capture stage. It accepts a word on a valid/ready handshake and shifts it out MSB-first, one bit per clock. It marks frame boundaries so the downstream SIPO can be aligned. Back-to-back words stream with no idle gap.

## Interface
- DATA_W, 8, word width in bits (>= 2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- data_in  input  DATA_W  word to transmit; sampled on accepted transfer
- load_valid  input  1  producer has a word on data_in
- load_ready  output  1  block can accept a word this cycle (combinational from state)
- serial_out  output  1  registered serial bit
- bit_valid  output  1  serial_out carries a frame bit this cycle
- frame_start  output  1  high with the first (MSB) bit of each frame
- done  output  1  high with the final bit of each frame
- busy  output  1  frame in progress

## Operation
- Transfer occurs on a rising edge where load_valid && load_ready. data_in is captured into the shift register, and the bit counter is set to 0.
- FSM states:
  - IDLE: load_ready=1; transfer -> SHIFT.
  - SHIFT: present shift[DATA_W-1], shift left by 1, counter +1. At counter==DATA_W-1 -> PARITY if enabled, otherwise -> SHIFT (new transfer) or IDLE.
  - PARITY (macro only): present parity bit -> SHIFT (new transfer) or IDLE.
- load_ready=1 in IDLE and in the final cycle of a frame (last data bit, or parity bit when enabled). Otherwise 0.
- Transfer in the final cycle starts the next frame on the following cycle with no gap. frame_start follows done directly.
- load_valid while load_ready=0: ignored, no capture. The producer must hold the word.
- Bit counter is $clog2(DATA_W) bits wide, counts 0..DATA_W-1, and never wraps mid-frame.
- Reset (asserted at any time, including mid-frame): state=IDLE; shift register, counter, serial_out, bit_valid, frame_start, done and busy all 0. The in-flight frame is aborted with no done. load_ready reads 1 while in IDLE, but no transfer is taken while rst is high.

## Timing
- Transfer at edge E. After E: serial_out=data[DATA_W-1], bit_valid=1, frame_start=1, busy=1.
- After E+k (0 <= k < DATA_W): serial_out=data[DATA_W-1-k].
- Without parity:
  - done=1 in the cycle after E+DATA_W-1.
  - Frame length is DATA_W cycles.
  - After E+DATA_W with no new transfer: bit_valid=0, busy=0, serial_out=0.
- With parity:
  - Extra cycle after E+DATA_W, where serial_out=parity and done=1.
  - Frame length is DATA_W+1 cycles.
- frame_start and done are single-cycle pulses per frame. They coincide only if DATA_W=1, which is disallowed.
- All outputs except load_ready are registered.

## Configuration
- PISO_TX_PARITY_EN defined:
  - Adds the PARITY state. Parity bit = even parity (XOR of all captured data bits).
  - done, and the back-to-back load_ready window, move to the parity cycle.
  - Downstream must drop that bit using bit_valid/frame_start framing.
- Undefined:
  - No PARITY state and no parity logic.
  - Frame is exactly DATA_W bits, directly compatible with the 8-bit SIPO.

## Structure
- Shared package piso_pkg holds:
  - state enum (IDLE, SHIFT, PARITY)
  - default word width constant (8)
  - counter-width function
- One natural sub-module: piso_bit_cnt. It is a loadable up-counter with a terminal-count flag (count==DATA_W-1), reused for frame-end detection.
- FSM and shift register stay in piso_tx.

## Test plan
- Reset then idle: after rst deassert, load_ready=1; serial_out, bit_valid, frame_start, done and busy all 0.
- Single word 8'hA5 (no parity) -> serial_out 1,0,1,0,0,1,0,1 on consecutive cycles. frame_start on the first bit, done on the eighth, busy low on the ninth.
- Back-to-back 8'hF0 then 8'h0F, with load_valid held high -> 16 contiguous bits 11110000 00001111. done on bit 8 and frame_start on bit 9 in adjacent cycles.
- Backpressure: load_valid high mid-frame with 8'h3C -> no capture until the final bit cycle. Frame 2 equals 00111100.
- Reset at bit 4 of 8'hFF -> all outputs 0 next cycle, no done. The next word 8'h81 transmits cleanly as 10000001.
- With PISO_TX_PARITY_EN, send 8'h07 -> 00000111, then parity bit 1. done is on the 9th bit, and load_ready is high only in that cycle.
